bit_scan_unit: RTL

//  Parametrised, sequential lowest-first set-bit scanner: successor of our combinational 6-bit first-one finder.

---
 rtl/bit_scan_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bit_scan_unit.sv
// ---------------------------------------------------------------------------
// bit_scan_unit
//
// Sequential lowest-first set-bit scanner. A WIDTH-bit vector is accepted
// over a valid/ready handshake. The block then emits the indices of its set
// bits one output beat at a time, starting with the lowest. In FIRST mode
// only one beat is produced. In ALL mode there is one beat per set bit. An
// empty vector always produces exactly one "not found" beat.
//
// Parameters
//    WIDTH  bits in the scanned vector (2..64)
//    IDX_W  width of out_idx / out_seq, 2**IDX_W >= WIDTH
//
// Ports
//    clk        rising-edge clock
//    reset      asynchronous, active-high reset
//    in_valid   in_vec / in_mode valid
//    in_ready   block can accept a vector (only while idle)
//    in_vec     vector to scan
//    in_mode    0 = FIRST (one result), 1 = ALL (every set bit)
//    out_valid  result beat valid
//    out_ready  consumer accepts the beat
//    out_idx    index of the lowest remaining set bit (0 when none)
//    out_found  out_idx refers to a real set bit
//    out_last   final beat for the current vector
//    out_seq    0-based beat number within the current vector
// ---------------------------------------------------------------------------
module bit_scan_unit #(
   parameter int WIDTH = 6,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_found,
   output logic             out_last,
   output logic [IDX_W-1:0] out_seq
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   vec_q, vec_d;
   logic               mode_q, mode_d;
   logic [IDX_W-1:0]   seq_q, seq_d;

   logic [IDX_W-1:0]   scanIdx;
   logic               anySet;
   logic               singleSet;
   logic               lastBeat;
   logic [WIDTH-1:0]   vecMinusOne;

   // Priority chain over the remaining bits. Walking from the top down and
   // overwriting on every set bit leaves the lowest set index at the end,
   // and the loop elaborates for any legal WIDTH.
   always_comb begin
      scanIdx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec_q[i]) begin
            scanIdx = IDX_W'(i);
         end
      end
   end

   // v & (v-1) clears the lowest set bit. The same term is zero exactly
   // when at most one bit is set, which gives the single-bit test for free.
   always_comb begin
      vecMinusOne = vec_q - WIDTH'(1);
      anySet      = |vec_q;
      singleSet   = anySet && ((vec_q & vecMinusOne) == '0);
      lastBeat    = ~anySet | ~mode_q | singleSet;
   end

   // State, vector, mode and beat counter. The reset also abandons any scan
   // in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         vec_q   <= '0;
         mode_q  <= 1'b0;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         mode_q  <= mode_d;
         seq_q   <= seq_d;
      end
   end

   // Next-state logic. Idle only listens for a vector. Busy only listens for
   // the consumer, so input changes during a scan have no effect.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      mode_d  = mode_q;
      seq_d   = seq_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               vec_d   = in_vec;
               mode_d  = in_mode;
               seq_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (out_ready) begin
               if (lastBeat) begin
                  vec_d   = '0;
                  seq_d   = '0;
                  state_d = IDLE;
               end else begin
                  vec_d = vec_q & vecMinusOne;
                  seq_d = seq_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The outputs depend only on registered state. in_ready is also masked
   // by reset, because the reset value of the state would otherwise
   // advertise readiness while reset is still asserted.
   always_comb begin
      in_ready  = (state_q == IDLE) && !reset;
      out_valid = (state_q == BUSY);
      out_idx   = out_valid ? scanIdx : '0;
      out_found = out_valid & anySet;
      out_last  = out_valid & lastBeat;
      out_seq   = seq_q;
   end

endmodule
